// File: rtl/key_expansion_iter.sv
// key_expansion_iter: iterative AES-128/192/256 key schedule, one word per clock, round keys served by index.
// Optional KEYEXP_INV_MIX_EN adds InvMixColumns on middle round keys for the equivalent inverse cipher.
module key_expansion_iter #(
    parameter int MAX_NK = 8,
    parameter bit RD_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         mode_err,
    input  logic [3:0]   rd_idx,
    input  logic         rd_inv,
    output logic [127:0] rd_key
);
    localparam int WORD_SIZE  = 32;
    localparam int DATA_WIDTH = 128;
    localparam int DEPTH      = 4 * (MAX_NK + 7);
    localparam int AW         = $clog2(DEPTH);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
    state_t                 state, next;
    logic [0:7][31:0]       win;
    logic [WORD_SIZE-1:0]   store [DEPTH];
    logic [WORD_SIZE-1:0]   prev, far, sub, temp, new_w;
    logic [AW-1:0]          i, last, base;
    logic [3:0]             j, nk, nr, nk_dec;
    logic [2:0]             far_idx;
    logic [7:0]             rcon;
    logic                   legal, accept, reject, kv, merr;
    logic [DATA_WIDTH-1:0]  plain, key_c, rd_q;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    assign nk_dec = key_mode == 2'b00 ? 4'd4 : key_mode == 2'b01 ? 4'd6 : 4'd8;
    assign legal  = key_mode != 2'b11 && nk_dec <= 4'(MAX_NK);

    always_comb begin
        next   = state;
        accept = 1'b0;
        reject = 1'b0;
        busy   = state == LOAD || state == EXPAND;
        done   = state == DONE;
        case (state)
            IDLE: begin
                accept = start && legal;
                reject = start && !legal;
                next   = accept ? LOAD : IDLE;
            end
            LOAD:    next = EXPAND;
            EXPAND:  next = i == last ? DONE : EXPAND;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kv    <= 1'b0;
            merr  <= 1'b0;
            rd_q  <= '0;
        end else begin
            state <= next;
            merr  <= reject;
            kv    <= accept ? 1'b0 : (state == EXPAND && i == last) ? 1'b1 : kv;
            rd_q  <= key_c;
        end
    end

    assign keys_valid = kv;
    assign mode_err   = merr;

    // The window always holds w[i-8..i-1]; w[i-Nk] sits at slot 8-Nk.
    assign far_idx = 3'(4'd8 - nk);

    always_comb begin
        prev  = win[7];
        far   = win[far_idx];
        sub   = sub_word(j == 4'd0 ? {prev[23:0], prev[31:24]} : prev);
        temp  = j == 4'd0 ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && j == 4'd4) ? sub : prev;
        new_w = far ^ temp;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            nk   <= nk_dec;
            nr   <= nk_dec + 4'd6;
            last <= AW'(4 * nk_dec + 27);
        end
        if (state == LOAD) begin
            win  <= key_in >> (32 * (8 - nk));
            i    <= AW'(nk);
            j    <= 4'd0;
            rcon <= 8'h01;
        end
        if (state == EXPAND) begin
            win  <= {win[1:7], new_w};
            i    <= i + AW'(1);
            j    <= j == nk - 4'd1 ? 4'd0 : j + 4'd1;
            rcon <= j == 4'd0 ? xt(rcon) : rcon;
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD)
            for (int k = 0; k < MAX_NK; k++)
                if (4'(k) < nk) store[AW'(k)] <= key_in[255-32*k -: 32];
        if (state == EXPAND) store[i] <= new_w;
    end

    assign base  = AW'({rd_idx, 2'b00});
    assign plain = rd_idx > nr ? '0
                 : {store[base], store[base+AW'(1)], store[base+AW'(2)], store[base+AW'(3)]};

`ifdef KEYEXP_INV_MIX_EN
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gm(s[127-32*c-8*r -: 8], 4'he)
                                     ^ gm(s[127-32*c-8*((r+1)%4) -: 8], 4'hb)
                                     ^ gm(s[127-32*c-8*((r+2)%4) -: 8], 4'hd)
                                     ^ gm(s[127-32*c-8*((r+3)%4) -: 8], 4'h9);
        return o;
    endfunction

    assign key_c = (rd_inv && rd_idx != 4'd0 && rd_idx < nr) ? inv_mix(plain) : plain;
`else
    logic unused_rd_inv;
    assign unused_rd_inv = rd_inv;
    assign key_c = plain;
`endif

    assign rd_key = RD_REG ? rd_q : key_c;
endmodule
